// File: rtl/rv32i_types.sv
// Shared RV32I core types: branch comparator op codes and the bimodal
// predictor counter encoding with its saturating update rule.
package rv32i_types;

  localparam logic [2:0] BR_OP_EQ  = 3'b000;
  localparam logic [2:0] BR_OP_NE  = 3'b001;
  localparam logic [2:0] BR_OP_LT  = 3'b100;
  localparam logic [2:0] BR_OP_GE  = 3'b101;
  localparam logic [2:0] BR_OP_LTU = 3'b110;
  localparam logic [2:0] BR_OP_GEU = 3'b111;

  typedef enum logic [1:0] {
    SN = 2'b00,
    WN = 2'b01,
    WT = 2'b10,
    ST = 2'b11
  } bp_cnt_t;

  function automatic bp_cnt_t bp_cnt_next(input bp_cnt_t cnt, input logic taken);
    bp_cnt_t nxt;
    nxt = cnt;
    if (taken) begin
      case (cnt)
        SN:      nxt = WN;
        WN:      nxt = WT;
        default: nxt = ST;
      endcase
    end else begin
      case (cnt)
        ST:      nxt = WT;
        WT:      nxt = WN;
        default: nxt = SN;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Pattern history table: flop array of 2-bit counters with one combinational
// read port and one read-modify-write update port.
module bp_counter_table
  import rv32i_types::*;
#(
  parameter int PHT_DEPTH = 256,
  parameter int IDX_BITS  = $clog2(PHT_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] rd_idx,
  output bp_cnt_t             rd_cnt,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_taken
);

  bp_cnt_t tbl [PHT_DEPTH];

  assign rd_cnt = tbl[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_DEPTH; i++) tbl[i] <= WN;
    end else if (wr_en) begin
      tbl[wr_idx] <= bp_cnt_next(tbl[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch direction predictor: PHT lookup with update-collision bypass,
// registered one-cycle response, and saturating mispredict counter.
module branch_predictor
  import rv32i_types::*;
#(
  parameter int PHT_DEPTH = 256,
  parameter int IDX_BITS  = $clog2(PHT_DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pred_valid,
  input  logic [31:0] pred_pc,
  input  logic        pred_stall,
  input  logic        pred_flush,
  output logic        pred_resp_valid,
  output logic        pred_taken,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_pred_taken,
  output logic [31:0] mispredict_count
);

  logic [IDX_BITS-1:0] rd_idx_p0;
  logic [IDX_BITS-1:0] wr_idx_p0;
  bp_cnt_t             rd_cnt_p0;
  bp_cnt_t             byp_cnt_p0;
  logic                lookup_p0;
  logic                mispred_p0;
  logic                unused_pc_bits;

  assign rd_idx_p0  = pred_pc[IDX_BITS+1:2];
  assign wr_idx_p0  = upd_pc[IDX_BITS+1:2];
  assign lookup_p0  = pred_valid && !pred_stall && !pred_flush;
  assign mispred_p0 = upd_valid && (upd_taken != upd_pred_taken);
  assign unused_pc_bits = ^{pred_pc[1:0], upd_pc[1:0]};

  bp_counter_table #(
    .PHT_DEPTH (PHT_DEPTH),
    .IDX_BITS  (IDX_BITS)
  ) u_pht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (rd_idx_p0),
    .rd_cnt   (rd_cnt_p0),
    .wr_en    (upd_valid),
    .wr_idx   (wr_idx_p0),
    .wr_taken (upd_taken)
  );

  // Same-index update this cycle: predict from the counter as it will be written.
  always_comb begin
    byp_cnt_p0 = rd_cnt_p0;
    if (upd_valid && (wr_idx_p0 == rd_idx_p0))
      byp_cnt_p0 = bp_cnt_next(rd_cnt_p0, upd_taken);
  end

  // ---- p0 -> p1: response register and statistics ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_resp_valid <= 1'b0;
      pred_taken      <= 1'b0;
    end else if (pred_flush) begin
      pred_resp_valid <= 1'b0;
    end else if (lookup_p0) begin
      pred_resp_valid <= 1'b1;
      pred_taken      <= byp_cnt_p0[1];
    end else if (!pred_stall) begin
      pred_resp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      mispredict_count <= 32'd0;
    else if (mispred_p0 && (mispredict_count != 32'hFFFF_FFFF))
      mispredict_count <= mispredict_count + 32'd1;
  end

endmodule
